ysyx_24100006_axi_arbiter: RTL and testbench

Two-master to one-master AXI4 arbiter that sits directly upstream of the AXI crossbar. It merges IFU instruction fetches (read-only) and LSU loads/stores onto the single master port the crossbar decodes. The grant is held for a whole transaction: AR through the last R beat, or AW/W through B. The arbiter also supplies the crossbar's byte-offset input (m_addr_suffix) for the transaction that is currently granted.

---
 rtl/ysyx_24100006_axi_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_ysyx_24100006_axi_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_axi_arbiter.sv
// Two-to-one AXI4 arbiter in front of the crossbar: IFU (read-only) and LSU share one master port.
// A grant covers a whole transaction; m_addr_suffix carries the granted address's byte offset.
module ysyx_24100006_axi_arbiter #(
    parameter int RR_EN  = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic [7:0]        ifu_arlen,
    input  logic [2:0]        ifu_arsize,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [1:0]        ifu_rresp,
    output logic              ifu_rlast,

    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic [7:0]        lsu_arlen,
    input  logic [2:0]        lsu_arsize,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [1:0]        lsu_rresp,
    output logic              lsu_rlast,
    input  logic              lsu_awvalid,
    output logic              lsu_awready,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic [7:0]        lsu_awlen,
    input  logic [2:0]        lsu_awsize,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [3:0]        lsu_wstrb,
    input  logic              lsu_wlast,
    output logic              lsu_bvalid,
    input  logic              lsu_bready,
    output logic [1:0]        lsu_bresp,

    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wlast,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    input  logic [1:0]        m_axi_bresp,

    output logic [1:0]        m_addr_suffix
);

    typedef enum logic [1:0] {
        IDLE,
        IFU_RD,
        LSU_RD,
        LSU_WR
    } state_t;

    typedef enum logic {
        GRANT_IFU,
        GRANT_LSU
    } grant_t;

    state_t     state;
    state_t     state_next;
    grant_t     last_grant;
    grant_t     last_grant_next;
    logic [1:0] suffix_next;
    logic       lsu_wins_tie;
    logic       r_done;
    logic       b_done;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state         <= IDLE;
            last_grant    <= GRANT_IFU;
            m_addr_suffix <= 2'b00;
        end else begin
            state         <= state_next;
            last_grant    <= last_grant_next;
            m_addr_suffix <= suffix_next;
        end
    end

    // With round-robin off the LSU always wins a tie; otherwise the side not served last wins.
    assign lsu_wins_tie = (RR_EN == 0) || (last_grant == GRANT_IFU);
    assign r_done       = m_axi_rvalid && m_axi_rready && m_axi_rlast;
    assign b_done       = m_axi_bvalid && m_axi_bready;

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        suffix_next     = m_addr_suffix;
        case (state)
            IDLE: begin
                if (lsu_awvalid) begin
                    state_next      = LSU_WR;
                    last_grant_next = GRANT_LSU;
                    suffix_next     = lsu_awaddr[1:0];
                end else if (lsu_arvalid && (!ifu_arvalid || lsu_wins_tie)) begin
                    state_next      = LSU_RD;
                    last_grant_next = GRANT_LSU;
                    suffix_next     = lsu_araddr[1:0];
                end else if (ifu_arvalid) begin
                    state_next      = IFU_RD;
                    last_grant_next = GRANT_IFU;
                    suffix_next     = ifu_araddr[1:0];
                end
            end
            IFU_RD, LSU_RD: begin
                if (r_done) begin
                    state_next = IDLE;
                end
            end
            LSU_WR: begin
                if (b_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output is defaulted before the case, so no path through it can infer a latch.
        ifu_arready   = 1'b0;
        ifu_rvalid    = 1'b0;
        ifu_rdata     = '0;
        ifu_rresp     = 2'b00;
        ifu_rlast     = 1'b0;
        lsu_arready   = 1'b0;
        lsu_rvalid    = 1'b0;
        lsu_rdata     = '0;
        lsu_rresp     = 2'b00;
        lsu_rlast     = 1'b0;
        lsu_awready   = 1'b0;
        lsu_wready    = 1'b0;
        lsu_bvalid    = 1'b0;
        lsu_bresp     = 2'b00;
        m_axi_arvalid = 1'b0;
        m_axi_araddr  = '0;
        m_axi_arlen   = 8'd0;
        m_axi_arsize  = 3'd0;
        m_axi_rready  = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_awaddr  = '0;
        m_axi_awlen   = 8'd0;
        m_axi_awsize  = 3'd0;
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = 4'd0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        case (state)
            IFU_RD: begin
                m_axi_arvalid = ifu_arvalid;
                m_axi_araddr  = ifu_araddr;
                m_axi_arlen   = ifu_arlen;
                m_axi_arsize  = ifu_arsize;
                m_axi_rready  = ifu_rready;
                ifu_arready   = m_axi_arready;
                ifu_rvalid    = m_axi_rvalid;
                ifu_rdata     = m_axi_rdata;
                ifu_rresp     = m_axi_rresp;
                ifu_rlast     = m_axi_rlast;
            end
            LSU_RD: begin
                m_axi_arvalid = lsu_arvalid;
                m_axi_araddr  = lsu_araddr;
                m_axi_arlen   = lsu_arlen;
                m_axi_arsize  = lsu_arsize;
                m_axi_rready  = lsu_rready;
                lsu_arready   = m_axi_arready;
                lsu_rvalid    = m_axi_rvalid;
                lsu_rdata     = m_axi_rdata;
                lsu_rresp     = m_axi_rresp;
                lsu_rlast     = m_axi_rlast;
            end
            LSU_WR: begin
                m_axi_awvalid = lsu_awvalid;
                m_axi_awaddr  = lsu_awaddr;
                m_axi_awlen   = lsu_awlen;
                m_axi_awsize  = lsu_awsize;
                m_axi_wvalid  = lsu_wvalid;
                m_axi_wdata   = lsu_wdata;
                m_axi_wstrb   = lsu_wstrb;
                m_axi_wlast   = lsu_wlast;
                m_axi_bready  = lsu_bready;
                lsu_awready   = m_axi_awready;
                lsu_wready    = m_axi_wready;
                lsu_bvalid    = m_axi_bvalid;
                lsu_bresp     = m_axi_bresp;
            end
            default: ;
        endcase
    end

    // The LSU issues either a read or a write at a time, never both.
    a_lsu_one_direction: assert property (@(posedge clk) disable iff (reset)
        !(lsu_arvalid && lsu_awvalid));

endmodule

// File: tb/tb_ysyx_24100006_axi_arbiter.sv
// Bench for the IFU/LSU AXI arbiter: a round-robin and a fixed-priority instance share stimulus,
// a transaction-level ownership model predicts both, and directed probes pin literal values.
module tb_ysyx_24100006_axi_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int FIXED_IDX = 1;

    typedef enum int {NOBODY, IFU_READ, LSU_READ, LSU_WRITE} owner_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              ifu_arvalid, ifu_rready;
    logic [ADDR_W-1:0] ifu_araddr;
    logic [7:0]        ifu_arlen;
    logic [2:0]        ifu_arsize;
    logic              lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid, lsu_wlast, lsu_bready;
    logic [ADDR_W-1:0] lsu_araddr, lsu_awaddr;
    logic [7:0]        lsu_arlen, lsu_awlen;
    logic [2:0]        lsu_arsize, lsu_awsize;
    logic [DATA_W-1:0] lsu_wdata;
    logic [3:0]        lsu_wstrb;
    logic              m_axi_arready, m_axi_rvalid, m_axi_rlast, m_axi_awready, m_axi_wready, m_axi_bvalid;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp, m_axi_bresp;

    logic              ifu_arready_o [2];
    logic              ifu_rvalid_o [2];
    logic [DATA_W-1:0] ifu_rdata_o [2];
    logic [1:0]        ifu_rresp_o [2];
    logic              ifu_rlast_o [2];
    logic              lsu_arready_o [2];
    logic              lsu_rvalid_o [2];
    logic [DATA_W-1:0] lsu_rdata_o [2];
    logic [1:0]        lsu_rresp_o [2];
    logic              lsu_rlast_o [2];
    logic              lsu_awready_o [2];
    logic              lsu_wready_o [2];
    logic              lsu_bvalid_o [2];
    logic [1:0]        lsu_bresp_o [2];
    logic              m_axi_arvalid_o [2];
    logic [ADDR_W-1:0] m_axi_araddr_o [2];
    logic [7:0]        m_axi_arlen_o [2];
    logic [2:0]        m_axi_arsize_o [2];
    logic              m_axi_rready_o [2];
    logic              m_axi_awvalid_o [2];
    logic [ADDR_W-1:0] m_axi_awaddr_o [2];
    logic [7:0]        m_axi_awlen_o [2];
    logic [2:0]        m_axi_awsize_o [2];
    logic              m_axi_wvalid_o [2];
    logic [DATA_W-1:0] m_axi_wdata_o [2];
    logic [3:0]        m_axi_wstrb_o [2];
    logic              m_axi_wlast_o [2];
    logic              m_axi_bready_o [2];
    logic [1:0]        m_addr_suffix_o [2];

    // Instance 0 is round-robin, instance 1 is fixed LSU priority.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        ysyx_24100006_axi_arbiter #(
            .RR_EN  ((g == FIXED_IDX) ? 0 : 1),
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .ifu_arvalid   (ifu_arvalid),
            .ifu_arready   (ifu_arready_o[g]),
            .ifu_araddr    (ifu_araddr),
            .ifu_arlen     (ifu_arlen),
            .ifu_arsize    (ifu_arsize),
            .ifu_rvalid    (ifu_rvalid_o[g]),
            .ifu_rready    (ifu_rready),
            .ifu_rdata     (ifu_rdata_o[g]),
            .ifu_rresp     (ifu_rresp_o[g]),
            .ifu_rlast     (ifu_rlast_o[g]),
            .lsu_arvalid   (lsu_arvalid),
            .lsu_arready   (lsu_arready_o[g]),
            .lsu_araddr    (lsu_araddr),
            .lsu_arlen     (lsu_arlen),
            .lsu_arsize    (lsu_arsize),
            .lsu_rvalid    (lsu_rvalid_o[g]),
            .lsu_rready    (lsu_rready),
            .lsu_rdata     (lsu_rdata_o[g]),
            .lsu_rresp     (lsu_rresp_o[g]),
            .lsu_rlast     (lsu_rlast_o[g]),
            .lsu_awvalid   (lsu_awvalid),
            .lsu_awready   (lsu_awready_o[g]),
            .lsu_awaddr    (lsu_awaddr),
            .lsu_awlen     (lsu_awlen),
            .lsu_awsize    (lsu_awsize),
            .lsu_wvalid    (lsu_wvalid),
            .lsu_wready    (lsu_wready_o[g]),
            .lsu_wdata     (lsu_wdata),
            .lsu_wstrb     (lsu_wstrb),
            .lsu_wlast     (lsu_wlast),
            .lsu_bvalid    (lsu_bvalid_o[g]),
            .lsu_bready    (lsu_bready),
            .lsu_bresp     (lsu_bresp_o[g]),
            .m_axi_arvalid (m_axi_arvalid_o[g]),
            .m_axi_arready (m_axi_arready),
            .m_axi_araddr  (m_axi_araddr_o[g]),
            .m_axi_arlen   (m_axi_arlen_o[g]),
            .m_axi_arsize  (m_axi_arsize_o[g]),
            .m_axi_rvalid  (m_axi_rvalid),
            .m_axi_rready  (m_axi_rready_o[g]),
            .m_axi_rdata   (m_axi_rdata),
            .m_axi_rresp   (m_axi_rresp),
            .m_axi_rlast   (m_axi_rlast),
            .m_axi_awvalid (m_axi_awvalid_o[g]),
            .m_axi_awready (m_axi_awready),
            .m_axi_awaddr  (m_axi_awaddr_o[g]),
            .m_axi_awlen   (m_axi_awlen_o[g]),
            .m_axi_awsize  (m_axi_awsize_o[g]),
            .m_axi_wvalid  (m_axi_wvalid_o[g]),
            .m_axi_wready  (m_axi_wready),
            .m_axi_wdata   (m_axi_wdata_o[g]),
            .m_axi_wstrb   (m_axi_wstrb_o[g]),
            .m_axi_wlast   (m_axi_wlast_o[g]),
            .m_axi_bvalid  (m_axi_bvalid),
            .m_axi_bready  (m_axi_bready_o[g]),
            .m_axi_bresp   (m_axi_bresp),
            .m_addr_suffix (m_addr_suffix_o[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: who owns the master port, who was served last, granted byte offset.
    owner_t     owner [2];
    logic       last_lsu [2];
    logic [1:0] sfx [2];
    bit         model_on = 1'b0;

    always @(posedge clk) begin
        if (reset) model_on <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                owner[i]    <= NOBODY;
                last_lsu[i] <= 1'b0;
                sfx[i]      <= 2'b00;
            end else begin
                case (owner[i])
                    NOBODY: begin
                        if (lsu_awvalid) begin
                            owner[i] <= LSU_WRITE; last_lsu[i] <= 1'b1; sfx[i] <= lsu_awaddr[1:0];
                        end else if (lsu_arvalid && (!ifu_arvalid || i == FIXED_IDX || !last_lsu[i])) begin
                            owner[i] <= LSU_READ; last_lsu[i] <= 1'b1; sfx[i] <= lsu_araddr[1:0];
                        end else if (ifu_arvalid) begin
                            owner[i] <= IFU_READ; last_lsu[i] <= 1'b0; sfx[i] <= ifu_araddr[1:0];
                        end
                    end
                    IFU_READ:  if (m_axi_rvalid && ifu_rready && m_axi_rlast) owner[i] <= NOBODY;
                    LSU_READ:  if (m_axi_rvalid && lsu_rready && m_axi_rlast) owner[i] <= NOBODY;
                    LSU_WRITE: if (m_axi_bvalid && lsu_bready) owner[i] <= NOBODY;
                    default:   owner[i] <= NOBODY;
                endcase
            end
        end
    end

    task automatic compare_dut(input int i);
        bit f_ifu, f_lrd, f_wr;
        f_ifu = (owner[i] == IFU_READ);
        f_lrd = (owner[i] == LSU_READ);
        f_wr  = (owner[i] == LSU_WRITE);
        check($sformatf("dut%0d m_ar", i),
              {m_axi_arvalid_o[i], m_axi_araddr_o[i], m_axi_arlen_o[i], m_axi_arsize_o[i]},
              f_ifu ? {ifu_arvalid, ifu_araddr, ifu_arlen, ifu_arsize} :
              f_lrd ? {lsu_arvalid, lsu_araddr, lsu_arlen, lsu_arsize} : 44'd0);
        check($sformatf("dut%0d m_aw", i),
              {m_axi_awvalid_o[i], m_axi_awaddr_o[i], m_axi_awlen_o[i], m_axi_awsize_o[i]},
              f_wr ? {lsu_awvalid, lsu_awaddr, lsu_awlen, lsu_awsize} : 44'd0);
        check($sformatf("dut%0d m_w", i),
              {m_axi_wvalid_o[i], m_axi_wdata_o[i], m_axi_wstrb_o[i], m_axi_wlast_o[i]},
              f_wr ? {lsu_wvalid, lsu_wdata, lsu_wstrb, lsu_wlast} : 38'd0);
        check($sformatf("dut%0d m_rready_bready", i),
              {m_axi_rready_o[i], m_axi_bready_o[i]},
              {(f_ifu & ifu_rready) | (f_lrd & lsu_rready), f_wr & lsu_bready});
        check($sformatf("dut%0d ifu_side", i),
              {ifu_arready_o[i], ifu_rvalid_o[i], ifu_rdata_o[i], ifu_rresp_o[i], ifu_rlast_o[i]},
              f_ifu ? {m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast} : 37'd0);
        check($sformatf("dut%0d lsu_read_side", i),
              {lsu_arready_o[i], lsu_rvalid_o[i], lsu_rdata_o[i], lsu_rresp_o[i], lsu_rlast_o[i]},
              f_lrd ? {m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast} : 37'd0);
        check($sformatf("dut%0d lsu_write_side", i),
              {lsu_awready_o[i], lsu_wready_o[i], lsu_bvalid_o[i], lsu_bresp_o[i]},
              f_wr ? {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp} : 5'd0);
        check($sformatf("dut%0d suffix", i), m_addr_suffix_o[i], sfx[i]);
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            compare_dut(0);
            compare_dut(1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        #2;
    endtask

    localparam logic [31:0] IFU_A = 32'h8000_0100;
    localparam logic [31:0] LSU_A = 32'h8000_0203;

    initial begin
        reset = 1'b1;
        ifu_arvalid = 1'b0; ifu_araddr = '0; ifu_arlen = 8'd0; ifu_arsize = 3'd2; ifu_rready = 1'b1;
        lsu_arvalid = 1'b0; lsu_araddr = '0; lsu_arlen = 8'd0; lsu_arsize = 3'd2; lsu_rready = 1'b1;
        lsu_awvalid = 1'b0; lsu_awaddr = '0; lsu_awlen = 8'd0; lsu_awsize = 3'd2;
        lsu_wvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = 4'd0; lsu_wlast = 1'b0; lsu_bready = 1'b1;
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        tick();
        tick();
        reset = 1'b0;

        // IFU alone, single beat.
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000; ifu_arlen = 8'd0;
        probe();
        check("reset suffix", m_addr_suffix_o[0], 2'b00);
        check("ifu ar latency idle", m_axi_arvalid_o[0], 1'b0);
        tick();
        probe();
        check("ifu ar passes", {m_axi_arvalid_o[0], m_axi_araddr_o[0]}, {1'b1, 32'h8000_0000});
        check("ifu lsu_rvalid quiet", lsu_rvalid_o[0], 1'b0);
        tick();
        ifu_arvalid = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0000_0413; m_axi_rlast = 1'b1;
        probe();
        check("ifu rdata", {ifu_rvalid_o[0], ifu_rdata_o[0], ifu_rlast_o[0]}, {1'b1, 32'h0000_0413, 1'b1});
        check("ifu r lsu quiet", lsu_rvalid_o[0], 1'b0);
        tick();
        probe();
        check("ifu done model idle", owner[0], NOBODY);
        check("ifu done no forward", ifu_rvalid_o[0], 1'b0);
        tick();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;

        // Simultaneous reads after reset: round-robin alternates, fixed priority keeps LSU.
        reset = 1'b1;
        ifu_arvalid = 1'b1; ifu_araddr = IFU_A;
        lsu_arvalid = 1'b1; lsu_araddr = LSU_A;
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = 32'hA5A5_0001;
        tick();
        reset = 1'b0;
        probe();
        check("pair idle after reset", m_axi_arvalid_o[0], 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            probe();
            check($sformatf("rr grant addr %0d", k), m_axi_araddr_o[0], (k % 2 == 0) ? LSU_A : IFU_A);
            check($sformatf("rr suffix %0d", k), m_addr_suffix_o[0], (k % 2 == 0) ? 2'd3 : 2'd0);
            check($sformatf("rr ifu rvalid %0d", k), ifu_rvalid_o[0], (k % 2 == 1));
            check($sformatf("fixed grant addr %0d", k), m_axi_araddr_o[1], LSU_A);
            tick();
            if (k == 3) begin
                ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
            end
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        tick();

        // LSU store with W presented before AW.
        lsu_wvalid = 1'b1; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'hC; lsu_wlast = 1'b1;
        probe();
        check("w early not granted", {m_axi_wvalid_o[0], lsu_wready_o[0]}, 2'b00);
        tick();
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_0006; lsu_awlen = 8'd0;
        probe();
        check("aw latency idle", m_axi_awvalid_o[0], 1'b0);
        tick();
        probe();
        check("wr suffix", m_addr_suffix_o[0], 2'b10);
        check("wr aw pass", {m_axi_awvalid_o[0], m_axi_awaddr_o[0]}, {1'b1, 32'h8000_0006});
        check("wr w pass", {m_axi_wvalid_o[0], m_axi_wstrb_o[0], lsu_awready_o[0], lsu_wready_o[0]},
              {1'b1, 4'hC, 1'b1, 1'b1});
        tick();
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        probe();
        check("wr bresp", {lsu_bvalid_o[0], lsu_bresp_o[0], m_axi_bready_o[0]}, {1'b1, 2'b00, 1'b1});
        tick();
        m_axi_bvalid = 1'b0;
        probe();
        check("wr done model idle", owner[0], NOBODY);

        // IFU burst of four beats; LSU read raised mid-burst must wait.
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_1000; ifu_arlen = 8'd3;
        tick();
        probe();
        check("burst arlen", m_axi_arlen_o[0], 8'd3);
        for (int b = 0; b < 4; b++) begin
            tick();
            ifu_arvalid = 1'b0;
            m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1000_0000 + b; m_axi_rlast = (b == 3);
            if (b == 1) begin
                lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_2001; lsu_arlen = 8'd0;
            end
            probe();
            check($sformatf("burst beat %0d", b), {ifu_rdata_o[0], ifu_rlast_o[0]},
                  {32'h1000_0000 + b, b == 3});
            check($sformatf("burst lsu waits %0d", b), {m_axi_arvalid_o[1], lsu_arready_o[1]}, 2'b00);
        end
        tick();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        probe();
        check("burst gap idle", m_axi_arvalid_o[0], 1'b0);
        tick();
        probe();
        check("lsu granted after burst", {m_axi_arvalid_o[0], m_axi_araddr_o[0]}, {1'b1, 32'h8000_2001});
        check("lsu suffix", m_addr_suffix_o[0], 2'b01);

        // Error response on the LSU read still ends the transaction.
        tick();
        lsu_arvalid = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'hDEAD_BEEF; m_axi_rresp = 2'b10; m_axi_rlast = 1'b1;
        probe();
        check("err rresp", {lsu_rvalid_o[0], lsu_rresp_o[0], lsu_rdata_o[0]}, {1'b1, 2'b10, 32'hDEAD_BEEF});
        tick();
        m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
        probe();
        check("err done model idle", owner[0], NOBODY);
        check("err done no rready", m_axi_rready_o[0], 1'b0);

        // Reset during an IFU read.
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_3002; ifu_arlen = 8'd1;
        tick();
        reset = 1'b1;
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0000_0055;
        probe();
        check("pre-reset ifu granted", {m_axi_arvalid_o[0], m_axi_rready_o[0], m_addr_suffix_o[0]},
              {1'b1, 1'b1, 2'b10});
        tick();
        reset = 1'b0;
        ifu_arvalid = 1'b0; m_axi_rvalid = 1'b0;
        probe();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("post-reset quiet dut%0d", i),
                  {m_axi_arvalid_o[i], m_axi_rready_o[i], m_axi_awvalid_o[i], m_axi_wvalid_o[i],
                   m_axi_bready_o[i], m_addr_suffix_o[i]}, 7'd0);
        end
        check("post-reset model idle", owner[0], NOBODY);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

endmodule
